seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the board's 7-segment bank. It shares a single

---
 rtl/seven_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// that share one hex-to-segment decoder. Each digit is lit for DWELL_CYCLES,
// separated by GUARD_CYCLES with every anode off so the decoder output can
// settle on the next digit's nibble before its anode turns on (no ghosting).
//
// New display values arrive over a valid/ready handshake into a single pending
// buffer and are swapped into the displayed ("active") value only when the
// digit index wraps to 0, so one frame never mixes two values. While the scan
// is disabled (IDLE) the swap happens immediately.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   when defined, digit k>0 stays dark during its dwell if it and every more
//   significant nibble are zero; digit 0 is always lit. Timing is unchanged.
//
// Parameters:
//   NUM_DIGITS    digits scanned (2..8)
//   DWELL_CYCLES  clk cycles each digit is lit (>=1)
//   GUARD_CYCLES  clk cycles all anodes are off between digits (>=1)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = scan, 0 = go idle with all anodes off
//   load_valid  new display value offered
//   load_data   nibble k drives digit k (digit 0 = least significant)
//   load_ready  pending buffer empty, a value can be accepted
//   nibble      hex value for the shared decoder
//   anode_n     one-hot active-low digit enables
//   frame_tick  one-cycle pulse when the digit index wraps to 0
// All outputs are registered.
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        DRIVE
    } state_t;

    state_t                  state_reg,        state_next;
    logic [IW-1:0]           idx_reg,          idx_next;
    logic [CW-1:0]           cnt_reg,          cnt_next;
    logic [4*NUM_DIGITS-1:0] active_reg,       active_next;
    logic [4*NUM_DIGITS-1:0] pending_reg,      pending_next;
    logic                    pending_full_reg, pending_full_next;
    logic                    wrap;

    logic [NUM_DIGITS-1:0]   anode_n_reg,      anode_n_next;
    logic [3:0]              nibble_reg,       nibble_next;
    logic                    frame_tick_reg;
    logic                    load_ready_reg;

    logic [3:0]              digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_mask;

    // ---------------------------------------------------------------------
    // Next-state, counters and display buffers
    // ---------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        cnt_next          = cnt_reg;
        active_next       = active_reg;
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        wrap              = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    state_next = GUARD;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
                GUARD: begin
                    if (cnt_reg == GUARD_LAST) begin
                        state_next = DRIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_reg == DWELL_LAST) begin
                        state_next = GUARD;
                        cnt_next   = '0;
                        if (idx_reg == IDX_LAST) begin
                            idx_next = '0;
                            wrap     = 1'b1;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end

        // The swap needs a full buffer and acceptance needs an empty one, so
        // they can never both fire; the swap is listed first because it owns
        // the buffer on a frame boundary.
        if ((wrap || state_reg == IDLE) && pending_full_reg) begin
            active_next       = pending_reg;
            pending_full_next = 1'b0;
        end else if (load_valid && !pending_full_reg) begin
            pending_next      = load_data;
            pending_full_next = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Per-digit nibble view and leading-zero blanking mask, both taken from
    // the value that will be active next cycle so outputs stay aligned with
    // the registered state.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = active_next[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                // Dark only if this nibble and all above it are zero.
                assign blank_mask[gi] = ~|active_next[4*NUM_DIGITS-1:4*gi];
            end
`else
            assign blank_mask[gi] = 1'b0;
`endif
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output decode. The nibble follows the upcoming digit through GUARD so
    // the decoder has settled by the time the anode is enabled.
    // ---------------------------------------------------------------------
    always_comb begin
        anode_n_next = '1;
        nibble_next  = 4'h0;
        if (state_next != IDLE) begin
            nibble_next = digit_val[idx_next];
        end
        if (state_next == DRIVE && !blank_mask[idx_next]) begin
            anode_n_next[idx_next] = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            cnt_reg          <= '0;
            active_reg       <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            anode_n_reg      <= '1;
            nibble_reg       <= 4'h0;
            frame_tick_reg   <= 1'b0;
            load_ready_reg   <= 1'b1;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            cnt_reg          <= cnt_next;
            active_reg       <= active_next;
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            anode_n_reg      <= anode_n_next;
            nibble_reg       <= nibble_next;
            frame_tick_reg   <= wrap;
            load_ready_reg   <= !pending_full_next;
        end
    end

    assign load_ready = load_ready_reg;
    assign nibble     = nibble_reg;
    assign anode_n    = anode_n_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for seven_seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4,
// GUARD_CYCLES=1 (5 cycles per digit, 20 cycles per frame).
// Directed vectors with hand-computed expectations. Outputs are sampled 1 time
// unit after the rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  nibble;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(4),
        .GUARD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .nibble    (nibble),
        .anode_n   (anode_n),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a value while idle: one cycle to accept, one to copy into active.
    task automatic load_idle(input logic [15:0] val);
        load_valid = 1'b1;
        load_data  = val;
        tick();
        check("idle_accept_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
        tick();
        check("idle_copy_ready", 32'(load_ready), 32'h1);
        $display("[TB] idle load %h", val);
    endtask

    // Starts at the guard cycle of digit 0, ends at the next frame's guard
    // cycle of digit 0. lit[d]=0 means digit d is expected dark in its dwell.
    // Any load_valid is dropped after the first cycle.
    task automatic check_frame(input logic [15:0] val, input logic tick_exp, input logic [3:0] lit);
        logic [3:0] exp_an;
        logic [3:0] exp_nib;
        for (int d = 0; d < 4; d++) begin
            exp_nib = val[4*d +: 4];
            check("guard_anode", 32'(anode_n), 32'hF);
            check("guard_nibble", 32'(nibble), 32'(exp_nib));
            check("guard_tick", 32'(frame_tick), 32'((d == 0) && tick_exp));
            tick();
            if (d == 0) load_valid = 1'b0;
            exp_an = 4'hF;
            if (lit[d]) exp_an[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                check("drive_anode", 32'(anode_n), 32'(exp_an));
                check("drive_nibble", 32'(nibble), 32'(exp_nib));
                check("drive_tick", 32'(frame_tick), 32'h0);
                tick();
            end
        end
        $display("[TB] frame %h checked", val);
    endtask

    initial begin
        logic [15:0] old_val;
        logic [3:0]  exp_nib;
        logic [3:0]  lit_0070;
        logic [3:0]  lit_0000;

        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        repeat (2) tick();
        check("rst_anode", 32'(anode_n), 32'hF);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        tick();

        // Reset while a digit is lit.
        load_idle(16'h1234);
        enable = 1'b1;
        tick();
        tick();
        check("pre_rst_anode", 32'(anode_n), 32'hE);
        check("pre_rst_nibble", 32'(nibble), 32'h4);
        rst_n = 1'b0;
        #2;
        check("async_rst_anode", 32'(anode_n), 32'hF);
        check("async_rst_nibble", 32'(nibble), 32'h0);
        check("async_rst_ready", 32'(load_ready), 32'h1);
        check("async_rst_tick", 32'(frame_tick), 32'h0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("[TB] mid-drive reset checked");

        // Basic scan of 1234.
        load_idle(16'h1234);
        enable = 1'b1;
        tick();
        check_frame(16'h1234, 1'b0, 4'hF);

        // Frame 2: load ABCD early, then hold 5678 valid across the swap.
        check("f2_tick", 32'(frame_tick), 32'h1);
        check("f2_ready", 32'(load_ready), 32'h1);
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        tick();
        load_data  = 16'h5678;
        old_val    = 16'h1234;
        for (int c = 1; c < 20; c++) begin
            exp_nib = old_val[4*(c/5) +: 4];
            check("hold_ready", 32'(load_ready), 32'h0);
            check("no_tear_nibble", 32'(nibble), 32'(exp_nib));
            tick();
        end
        $display("[TB] ABCD accepted, 5678 held through frame");
        check("swap_ready", 32'(load_ready), 32'h1);
        check_frame(16'hABCD, 1'b1, 4'hF);
        check("accepted_5678_ready", 32'(load_ready), 32'h1);
        check_frame(16'h5678, 1'b1, 4'hF);
        check("no_dup_ready", 32'(load_ready), 32'h1);
        check("no_dup_nibble", 32'(nibble), 32'h8);

        // Disable while digit 2 is lit, then restart.
        repeat (12) tick();
        check("d2_lit_anode", 32'(anode_n), 32'hB);
        check("d2_lit_nibble", 32'(nibble), 32'h6);
        enable = 1'b0;
        tick();
        check("disable_anode", 32'(anode_n), 32'hF);
        check("disable_tick", 32'(frame_tick), 32'h0);
        tick();
        check("idle_anode", 32'(anode_n), 32'hF);
        enable = 1'b1;
        tick();
        check_frame(16'h5678, 1'b0, 4'hF);
        $display("[TB] disable/re-enable checked");

        // Leading-zero values.
`ifdef LEADING_ZERO_BLANK_EN
        lit_0070 = 4'b0011;
        lit_0000 = 4'b0001;
`else
        lit_0070 = 4'b1111;
        lit_0000 = 4'b1111;
`endif
        enable = 1'b0;
        tick();
        load_idle(16'h0070);
        enable = 1'b1;
        tick();
        check_frame(16'h0070, 1'b0, lit_0070);
        enable = 1'b0;
        tick();
        load_idle(16'h0000);
        enable = 1'b1;
        tick();
        check_frame(16'h0000, 1'b0, lit_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
